// File: rtl/periph_pkg.sv
// Shared definitions for the peripheral responder: command and status
// encodings, FSM states, register map indices and FIFO_STATUS layout.
package periph_pkg;

   // Request commands carried in the top two bits of to_peripheral.
   // 2'b00 and 2'b11 both mean "no request".
   localparam logic [1:0] CMD_READ  = 2'b01;
   localparam logic [1:0] CMD_WRITE = 2'b10;

   // Response status codes returned on from_peripheral.
   typedef enum logic [1:0] {
      STAT_READ_OK  = 2'b00,
      STAT_WRITE_OK = 2'b01,
      STAT_ERROR    = 2'b10
   } status_t;

   // Request/response sequencing states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_RESP = 2'b10
   } state_t;

   // Register map, indexed by word_addr[2:0].
   localparam logic [2:0] IDX_SCRATCH0    = 3'd0;
   localparam logic [2:0] IDX_SCRATCH1    = 3'd1;
   localparam logic [2:0] IDX_FIFO_DATA   = 3'd2;
   localparam logic [2:0] IDX_FIFO_STATUS = 3'd3;
   localparam logic [2:0] IDX_CYCLE       = 3'd4;
   localparam logic [2:0] IDX_DROP_COUNT  = 3'd5;

   // FIFO_STATUS bit layout.
   localparam int FIFO_STAT_EMPTY_BIT = 0;
   localparam int FIFO_STAT_FULL_BIT  = 1;
   localparam int FIFO_STAT_COUNT_LSB = 8;

endpackage

// File: rtl/peripheral_fifo.sv
// Small synchronous FIFO with wrapping pointers and an occupancy count.
// Pushes when full and pops when empty are ignored.
module peripheral_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push,
   input  logic [DATA_WIDTH-1:0]      push_data,
   input  logic                       pop,
   output logic [DATA_WIDTH-1:0]      pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      cnt;
   logic                  push_ok;
   logic                  pop_ok;

   assign full     = (cnt == CNT_W'(DEPTH));
   assign empty    = (cnt == '0);
   assign count    = cnt;
   assign pop_data = mem[rd_ptr];
   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;

   // Storage is plain data and needs no reset; only pointers and count do.
   always_ff @(posedge clock) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n).
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/peripheral_responder.sv
// Memory-mapped peripheral target: accepts one READ/WRITE at a time,
// applies it to a small register map at the accept edge and returns a
// single response strobe a fixed number of edges later.
module peripheral_responder
   import periph_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDRESS_BITS = 20,
   parameter int FIFO_DEPTH   = 4,
   parameter int RESP_LATENCY = 2
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [ADDRESS_BITS+1:0]   to_peripheral,
   input  logic [DATA_WIDTH-1:0]     to_peripheral_data,
   input  logic                      to_peripheral_valid,
   output logic [1:0]                from_peripheral,
   output logic [DATA_WIDTH-1:0]     from_peripheral_data,
   output logic                      from_peripheral_valid
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int LAT_W = (RESP_LATENCY < 2) ? 1 : $clog2(RESP_LATENCY);

   logic [1:0]              cmd;
   logic [ADDRESS_BITS-1:0] word_addr;
   logic [2:0]              index;
   logic                    addr_hi_zero;
   logic                    is_req;
   logic                    is_write;
   logic                    accept;
   logic                    drop_hit;

   state_t                  state;
   logic [LAT_W-1:0]        lat_cnt;

   logic [DATA_WIDTH-1:0]   scratch0;
   logic [DATA_WIDTH-1:0]   scratch1;
   logic [DATA_WIDTH-1:0]   cycle_count;
   logic [DATA_WIDTH-1:0]   drop_count;

   logic                    fifo_full;
   logic                    fifo_empty;
   logic [CNT_W-1:0]        fifo_count;
   logic [DATA_WIDTH-1:0]   fifo_pop_data;
   logic [DATA_WIDTH-1:0]   fifo_status_word;

   status_t                 rsp_status;
   logic [DATA_WIDTH-1:0]   rsp_data;
   logic                    dec_push;
   logic                    dec_pop;
   logic                    dec_scr0_we;
   logic                    dec_scr1_we;
   logic                    dec_drop_clr;

   status_t                 pend_status_p0;
   logic [DATA_WIDTH-1:0]   pend_data_p0;

   assign cmd          = to_peripheral[ADDRESS_BITS +: 2];
   assign word_addr    = to_peripheral[ADDRESS_BITS-1:0];
   assign index        = word_addr[2:0];
   assign addr_hi_zero = (word_addr[ADDRESS_BITS-1:3] == '0);
   assign is_write     = (cmd == CMD_WRITE);
   assign is_req       = to_peripheral_valid && ((cmd == CMD_READ) || (cmd == CMD_WRITE));
   assign accept       = is_req && ((state == ST_IDLE) || (state == ST_RESP));
   assign drop_hit     = is_req && (state == ST_WAIT);

   peripheral_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (accept && dec_push),
      .push_data (to_peripheral_data),
      .pop       (accept && dec_pop),
      .pop_data  (fifo_pop_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Assemble the read-only FIFO_STATUS word.
   always_comb begin
      fifo_status_word                                     = '0;
      fifo_status_word[FIFO_STAT_EMPTY_BIT]                = fifo_empty;
      fifo_status_word[FIFO_STAT_FULL_BIT]                 = fifo_full;
      fifo_status_word[FIFO_STAT_COUNT_LSB +: CNT_W]       = fifo_count;
   end

   // Decode the presented request into a response and its side effects.
   always_comb begin
      rsp_status   = STAT_ERROR;
      rsp_data     = '0;
      dec_push     = 1'b0;
      dec_pop      = 1'b0;
      dec_scr0_we  = 1'b0;
      dec_scr1_we  = 1'b0;
      dec_drop_clr = 1'b0;
      if (addr_hi_zero) begin
         case (index)
            IDX_SCRATCH0: begin
               if (is_write) begin
                  rsp_status  = STAT_WRITE_OK;
                  dec_scr0_we = 1'b1;
               end else begin
                  rsp_status = STAT_READ_OK;
                  rsp_data   = scratch0;
               end
            end
            IDX_SCRATCH1: begin
               if (is_write) begin
                  rsp_status  = STAT_WRITE_OK;
                  dec_scr1_we = 1'b1;
               end else begin
                  rsp_status = STAT_READ_OK;
                  rsp_data   = scratch1;
               end
            end
            IDX_FIFO_DATA: begin
               if (is_write) begin
                  if (!fifo_full) begin
                     rsp_status = STAT_WRITE_OK;
                     dec_push   = 1'b1;
                  end
               end else if (!fifo_empty) begin
                  rsp_status = STAT_READ_OK;
                  rsp_data   = fifo_pop_data;
                  dec_pop    = 1'b1;
               end
            end
            IDX_FIFO_STATUS: begin
               if (!is_write) begin
                  rsp_status = STAT_READ_OK;
                  rsp_data   = fifo_status_word;
               end
            end
            IDX_CYCLE: begin
               if (!is_write) begin
                  rsp_status = STAT_READ_OK;
                  rsp_data   = cycle_count;
               end
            end
            IDX_DROP_COUNT: begin
               if (is_write) begin
                  rsp_status   = STAT_WRITE_OK;
                  dec_drop_clr = 1'b1;
               end else begin
                  rsp_status = STAT_READ_OK;
                  rsp_data   = drop_count;
               end
            end
            default: begin
               rsp_status = STAT_ERROR;
            end
         endcase
      end
   end

   // Scratch registers, written only by an accepted WRITE.
   always_ff @(posedge clock) begin
      if (reset) begin
         scratch0 <= '0;
         scratch1 <= '0;
      end else begin
         if (accept && dec_scr0_we) begin
            scratch0 <= to_peripheral_data;
         end
         if (accept && dec_scr1_we) begin
            scratch1 <= to_peripheral_data;
         end
      end
   end

   // Free-running cycle counter and saturating dropped-request counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         cycle_count <= '0;
         drop_count  <= '0;
      end else begin
         cycle_count <= cycle_count + DATA_WIDTH'(1);
         if (accept && dec_drop_clr) begin
            drop_count <= '0;
         end else if (drop_hit && (drop_count != '1)) begin
            drop_count <= drop_count + DATA_WIDTH'(1);
         end
      end
   end

   // p0: response captured at the accept edge, held until it is presented.
   always_ff @(posedge clock) begin
      if (accept) begin
         pend_status_p0 <= rsp_status;
         pend_data_p0   <= rsp_data;
      end
   end

   // Sequencing FSM with registered response outputs (strobe lasts one cycle).
   always_ff @(posedge clock) begin
      if (reset) begin
         state                 <= ST_IDLE;
         lat_cnt               <= '0;
         from_peripheral       <= '0;
         from_peripheral_data  <= '0;
         from_peripheral_valid <= 1'b0;
      end else begin
         from_peripheral       <= '0;
         from_peripheral_data  <= '0;
         from_peripheral_valid <= 1'b0;
         case (state)
            ST_IDLE, ST_RESP: begin
               if (accept) begin
                  if (RESP_LATENCY == 1) begin
                     state                 <= ST_RESP;
                     from_peripheral       <= rsp_status;
                     from_peripheral_data  <= rsp_data;
                     from_peripheral_valid <= 1'b1;
                  end else begin
                     state   <= ST_WAIT;
                     lat_cnt <= LAT_W'(RESP_LATENCY - 1);
                  end
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_WAIT: begin
               lat_cnt <= lat_cnt - LAT_W'(1);
               if (lat_cnt == LAT_W'(1)) begin
                  state                 <= ST_RESP;
                  from_peripheral       <= pend_status_p0;
                  from_peripheral_data  <= pend_data_p0;
                  from_peripheral_valid <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_peripheral_responder.sv
// Scoreboard bench for peripheral_responder: instance 0 runs with a
// two-edge response latency, instance 1 with a one-edge latency.
module tb_peripheral_responder;

   localparam int DW = 32;
   localparam int AB = 20;

   localparam logic [1:0] RD  = 2'b01;
   localparam logic [1:0] WR  = 2'b10;
   localparam logic [1:0] OK  = 2'b00;
   localparam logic [1:0] WOK = 2'b01;
   localparam logic [1:0] ERR = 2'b10;

   logic          clock = 1'b0;
   logic          reset = 1'b1;

   logic [AB+1:0] tp0, tp1;
   logic [DW-1:0] tpd0, tpd1;
   logic          tpv0, tpv1;
   logic [1:0]    fp0, fp1;
   logic [DW-1:0] fpd0, fpd1;
   logic          fpv0, fpv1;

   typedef struct {
      int          due;
      logic [1:0]  st;
      logic [31:0] data;
      bit          cd;
   } exp_t;

   exp_t        q0[$];
   exp_t        q1[$];
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   int          rst_last = 0;
   logic [31:0] lastd0 = '0;

   peripheral_responder #(
      .DATA_WIDTH(DW), .ADDRESS_BITS(AB), .FIFO_DEPTH(4), .RESP_LATENCY(2)
   ) dut0 (
      .clock(clock), .reset(reset),
      .to_peripheral(tp0), .to_peripheral_data(tpd0), .to_peripheral_valid(tpv0),
      .from_peripheral(fp0), .from_peripheral_data(fpd0), .from_peripheral_valid(fpv0)
   );

   peripheral_responder #(
      .DATA_WIDTH(DW), .ADDRESS_BITS(AB), .FIFO_DEPTH(4), .RESP_LATENCY(1)
   ) dut1 (
      .clock(clock), .reset(reset),
      .to_peripheral(tp1), .to_peripheral_data(tpd1), .to_peripheral_valid(tpv1),
      .from_peripheral(fp1), .from_peripheral_data(fpd1), .from_peripheral_valid(fpv1)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=0x%0h want=0x%0h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   // Compare one instance's outputs against its scoreboard head.
   task automatic mon(input int inst, input logic v, input logic [1:0] s, input logic [31:0] d);
      exp_t e;
      bit   have;
      have = 1'b0;
      if (inst == 0) begin
         if (q0.size() > 0 && q0[0].due == cyc) begin
            e = q0.pop_front();
            have = 1'b1;
            lastd0 = d;
         end
      end else begin
         if (q1.size() > 0 && q1[0].due == cyc) begin
            e = q1.pop_front();
            have = 1'b1;
         end
      end
      if (have) begin
         check($sformatf("i%0d_valid", inst), {63'd0, v}, 64'd1);
         check($sformatf("i%0d_status", inst), {62'd0, s}, {62'd0, e.st});
         if (e.cd) check($sformatf("i%0d_data", inst), {32'd0, d}, {32'd0, e.data});
      end else if (v !== 1'b0 || s !== 2'b00 || d !== 32'd0) begin
         check($sformatf("i%0d_quiet", inst), {29'd0, v, s, d}, 64'd0);
      end
   endtask

   always @(negedge clock) begin
      mon(0, fpv0, fp0, fpd0);
      mon(1, fpv1, fp1, fpd1);
   end

   // Present one request for a single edge; optionally expect a response.
   task automatic req(input int inst, input logic [1:0] cmd, input logic [19:0] addr,
                      input logic [31:0] d, input bit exp_rsp,
                      input logic [1:0] st, input logic [31:0] ed, input bit cd);
      exp_t e;
      e.due  = cyc + ((inst == 0) ? 2 : 1);
      e.st   = st;
      e.data = ed;
      e.cd   = cd;
      if (inst == 0) begin
         tp0 = {cmd, addr}; tpd0 = d; tpv0 = 1'b1;
         if (exp_rsp) q0.push_back(e);
      end else begin
         tp1 = {cmd, addr}; tpd1 = d; tpv1 = 1'b1;
         if (exp_rsp) q1.push_back(e);
      end
      @(negedge clock);
      if (inst == 0) begin
         tp0 = '0; tpd0 = '0; tpv0 = 1'b0;
      end else begin
         tp1 = '0; tpd1 = '0; tpv1 = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Full-rate operation on instance 0: one request every two edges.
   task automatic op0(input logic [1:0] cmd, input logic [19:0] addr, input logic [31:0] d,
                      input logic [1:0] st, input logic [31:0] ed);
      req(0, cmd, addr, d, 1'b1, st, ed, 1'b1);
      idle(1);
   endtask

   initial begin
      logic [31:0] v1, v2, cexp;
      tp0 = '0; tpd0 = '0; tpv0 = 1'b0;
      tp1 = '0; tpd1 = '0; tpv1 = 1'b0;
      reset = 1'b1;
      idle(4);
      check("reset_out0", {29'd0, fpv0, fp0, fpd0}, 64'd0);
      check("reset_out1", {29'd0, fpv1, fp1, fpd1}, 64'd0);
      reset = 1'b0;
      rst_last = cyc;
      idle(1);

      // Scratch round trips
      op0(WR, 20'd0, 32'hDEADBEEF, WOK, 32'd0);
      op0(RD, 20'd0, 32'd0, OK, 32'hDEADBEEF);
      op0(WR, 20'd1, 32'h12345678, WOK, 32'd0);
      op0(RD, 20'd1, 32'd0, OK, 32'h12345678);

      // FIFO fill, overflow, drain, underflow
      for (int i = 1; i <= 4; i++) op0(WR, 20'd2, 32'(i), WOK, 32'd0);
      op0(RD, 20'd3, 32'd0, OK, 32'h402);
      op0(WR, 20'd2, 32'h5, ERR, 32'd0);
      for (int i = 1; i <= 4; i++) op0(RD, 20'd2, 32'd0, OK, 32'(i));
      op0(RD, 20'd2, 32'd0, ERR, 32'd0);
      op0(RD, 20'd3, 32'd0, OK, 32'h001);

      // Busy drop: middle request lands in WAIT and is discarded
      req(0, WR, 20'd1, 32'hAA, 1'b1, WOK, 32'd0, 1'b1);
      req(0, RD, 20'd0, 32'd0, 1'b0, OK, 32'd0, 1'b1);
      req(0, RD, 20'd1, 32'd0, 1'b1, OK, 32'hAA, 1'b1);
      idle(1);
      op0(RD, 20'd5, 32'd0, OK, 32'd1);
      op0(WR, 20'd5, 32'h0, WOK, 32'd0);
      op0(RD, 20'd5, 32'd0, OK, 32'd0);

      // Decode errors
      op0(RD, 20'h8, 32'd0, ERR, 32'd0);
      op0(RD, 20'h80000, 32'd0, ERR, 32'd0);
      op0(RD, 20'd6, 32'd0, ERR, 32'd0);
      op0(RD, 20'd7, 32'd0, ERR, 32'd0);
      op0(WR, 20'd3, 32'hFFFF, ERR, 32'd0);
      op0(WR, 20'd4, 32'h0, ERR, 32'd0);
      op0(RD, 20'd3, 32'd0, OK, 32'h001);

      // NONE / 11 commands are neither answered nor counted as drops
      req(0, RD, 20'd1, 32'd0, 1'b1, OK, 32'hAA, 1'b1);
      req(0, 2'b00, 20'd1, 32'd0, 1'b0, OK, 32'd0, 1'b1);
      idle(1);
      req(0, RD, 20'd1, 32'd0, 1'b1, OK, 32'hAA, 1'b1);
      req(0, 2'b11, 20'd0, 32'd0, 1'b0, OK, 32'd0, 1'b1);
      idle(1);
      req(0, 2'b00, 20'd0, 32'd0, 1'b0, OK, 32'd0, 1'b1);
      req(0, 2'b11, 20'd0, 32'd0, 1'b0, OK, 32'd0, 1'b1);
      op0(RD, 20'd5, 32'd0, OK, 32'd0);

      // CYCLE: exact value since reset release, then a 10-edge delta
      cexp = 32'(cyc - rst_last);
      req(0, RD, 20'd4, 32'd0, 1'b1, OK, cexp, 1'b1);
      idle(2);
      v1 = lastd0;
      idle(7);
      req(0, RD, 20'd4, 32'd0, 1'b1, OK, 32'd0, 1'b0);
      idle(3);
      v2 = lastd0;
      check("cycle_delta", {32'd0, v2 - v1}, 64'd10);

      // One-edge latency instance, a request on every edge
      req(1, WR, 20'd0, 32'h11, 1'b1, WOK, 32'd0, 1'b1);
      req(1, RD, 20'd0, 32'd0, 1'b1, OK, 32'h11, 1'b1);
      req(1, WR, 20'd1, 32'h22, 1'b1, WOK, 32'd0, 1'b1);
      req(1, RD, 20'd1, 32'd0, 1'b1, OK, 32'h22, 1'b1);
      req(1, WR, 20'd2, 32'h33, 1'b1, WOK, 32'd0, 1'b1);
      req(1, RD, 20'd3, 32'd0, 1'b1, OK, 32'h100, 1'b1);
      req(1, RD, 20'd2, 32'd0, 1'b1, OK, 32'h33, 1'b1);
      req(1, RD, 20'd2, 32'd0, 1'b1, ERR, 32'd0, 1'b1);
      req(1, RD, 20'd5, 32'd0, 1'b1, OK, 32'd0, 1'b1);
      idle(2);

      // Reset while a read is pending on instance 0
      op0(WR, 20'd0, 32'h55, WOK, 32'd0);
      op0(WR, 20'd2, 32'h77, WOK, 32'd0);
      req(0, RD, 20'd0, 32'd0, 1'b0, OK, 32'd0, 1'b1);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      idle(2);
      op0(RD, 20'd0, 32'd0, OK, 32'd0);
      op0(RD, 20'd3, 32'd0, OK, 32'h001);
      req(1, RD, 20'd0, 32'd0, 1'b1, OK, 32'd0, 1'b1);

      idle(4);
      check("q0_drained", 64'(q0.size()), 64'd0);
      check("q1_drained", 64'(q1.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
